// File: rtl/int_sequencer_fsm.sv
// Interrupt entry sequencer: accept, flush, push, two-half IDT fetch, settle and redirect.
// Latency: int_ack one cycle after the accepting edge; shortest accept-to-accept spacing is 8 cycles.
// Backpressure: waits in DRAIN for push_done and in IDT_LO/IDT_HI for mem_ready; optional INT_TIMEOUT_EN adds a 256-cycle IDT timeout.
module int_sequencer_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic       int_req,
    input  logic [7:0] int_vector,
    input  logic       int_enable,
    input  logic       push_done,
    input  logic       mem_ready,
    output logic       curr_state2,
    output logic       curr_state1,
    output logic       curr_state0,
    output logic       not_used,
    output logic       int_ack,
    output logic [7:0] int_vector_q,
    output logic       int_busy,
    output logic       int_error
);

    // The encoding is consumed bit-by-bit by the downstream decode cloud,
    // so the values are fixed and not left to the synthesis tool.
    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        FLUSH     = 3'b001,
        DEC_START = 3'b010,
        IDT_LO    = 3'b011,
        DRAIN     = 3'b100,
        IDT_HI    = 3'b101,
        SETTLE    = 3'b110,
        REDIRECT  = 3'b111
    } state_t;

    state_t     state_q, state_d;
    logic       ack_q, ack_d;
    logic [7:0] vec_q, vec_d;
    logic       busy_q, busy_d;

`ifdef INT_TIMEOUT_EN
    logic       err_q, err_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       in_idt;
    logic       idt_timeout;

    // Timeout fires only on the cycle the counter has saturated and memory still has not answered.
    assign in_idt      = (state_q == IDT_LO) || (state_q == IDT_HI);
    assign idt_timeout = in_idt && !mem_ready && (wait_cnt_q == 8'hFF);
`endif

    // Next-state and registered-output decode; defaults hold state and clear pulses.
    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        vec_d   = vec_q;
`ifdef INT_TIMEOUT_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // Masked requests are simply not seen; the source keeps the level up.
                if (int_req && int_enable) begin
                    state_d = FLUSH;
                    ack_d   = 1'b1;
                    vec_d   = int_vector;
                end
            end
            FLUSH:     state_d = DEC_START;
            DEC_START: state_d = DRAIN;
            DRAIN: begin
                if (push_done) begin
                    state_d = IDT_LO;
                end
            end
            IDT_LO: begin
                if (mem_ready) begin
                    state_d = IDT_HI;
                end
`ifdef INT_TIMEOUT_EN
                else if (idt_timeout) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
`endif
            end
            IDT_HI: begin
                if (mem_ready) begin
                    state_d = SETTLE;
                end
`ifdef INT_TIMEOUT_EN
                else if (idt_timeout) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
`endif
            end
            SETTLE:    state_d = REDIRECT;
            REDIRECT:  state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        // Busy is precomputed from the next state so the output is a plain flop.
        busy_d = (state_d != IDLE);
    end

`ifdef INT_TIMEOUT_EN
    // Wait counter: zeroed on every IDT entry (LO->HI included), counts stalled cycles, saturates.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (((state_d == IDT_LO) || (state_d == IDT_HI)) && (state_d != state_q)) begin
            wait_cnt_d = 8'h00;
        end else if (state_d == IDLE) begin
            wait_cnt_d = 8'h00;
        end else if (in_idt && !mem_ready && (wait_cnt_q != 8'hFF)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end
`endif

    // State and output registers; reset returns to IDLE immediately, independent of clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            vec_q   <= 8'h00;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
        end
    end

`ifdef INT_TIMEOUT_EN
    // Timeout bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q      <= 1'b0;
            wait_cnt_q <= 8'h00;
        end else begin
            err_q      <= err_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign int_error = err_q;
`else
    assign int_error = 1'b0;
`endif

    assign {curr_state2, curr_state1, curr_state0} = state_q;
    assign not_used     = 1'b0;
    assign int_ack      = ack_q;
    assign int_vector_q = vec_q;
    assign int_busy     = busy_q;

    // The acknowledge pulse always coincides with the first FLUSH cycle.
    ack_in_flush: assert property (@(posedge clk) disable iff (reset)
        int_ack |-> (state_q == FLUSH));

    // Busy must track the state register exactly.
    busy_matches_state: assert property (@(posedge clk) disable iff (reset)
        int_busy == (state_q != IDLE));

`ifdef INT_TIMEOUT_EN
    // An error pulse is only ever seen on the way back into IDLE.
    error_in_idle: assert property (@(posedge clk) disable iff (reset)
        int_error |-> (state_q == IDLE));
`endif

endmodule

// File: tb/tb_int_sequencer_fsm.sv
// Scoreboard bench for int_sequencer_fsm: directed vectors push per-cycle expectations.
// A negedge monitor pops one expectation per clock and compares every output.
// Direct checks cover the asynchronous reset behaviour, which has no clock edge to key on.
module tb_int_sequencer_fsm;

    localparam logic [2:0] S_IDLE = 3'b000, S_FLUSH = 3'b001, S_DEC = 3'b010, S_DRAIN = 3'b100;
    localparam logic [2:0] S_LO = 3'b011, S_HI = 3'b101, S_SET = 3'b110, S_RED = 3'b111;

    logic       clk = 1'b0;
    logic       reset;
    logic       int_req, int_enable, push_done, mem_ready;
    logic [7:0] int_vector;
    logic       curr_state2, curr_state1, curr_state0, not_used;
    logic       int_ack, int_busy, int_error;
    logic [7:0] int_vector_q;

    typedef struct packed {
        logic [2:0] st;
        logic       ack;
        logic       err;
        logic [7:0] vq;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       m_e;
    logic [7:0] cur_vq;
    int         n_checks = 0;
    int         n_fail   = 0;

    int_sequencer_fsm dut (
        .clk          (clk),
        .reset        (reset),
        .int_req      (int_req),
        .int_vector   (int_vector),
        .int_enable   (int_enable),
        .push_done    (push_done),
        .mem_ready    (mem_ready),
        .curr_state2  (curr_state2),
        .curr_state1  (curr_state1),
        .curr_state0  (curr_state0),
        .not_used     (not_used),
        .int_ack      (int_ack),
        .int_vector_q (int_vector_q),
        .int_busy     (int_busy),
        .int_error    (int_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: inputs already set are sampled at this edge; the expected
    // post-edge outputs are queued for the monitor.
    task automatic cyc(input logic [2:0] st, input logic ack, input logic err);
        exp_t e;
        @(posedge clk);
        e.st  = st;
        e.ack = ack;
        e.err = err;
        e.vq  = cur_vq;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(S_IDLE, 1'b0, 1'b0);
    endtask

    // Shortest path after acceptance, with push_done and mem_ready held high.
    task automatic fast_tail();
        cyc(S_DEC,   1'b0, 1'b0);
        cyc(S_DRAIN, 1'b0, 1'b0);
        cyc(S_LO,    1'b0, 1'b0);
        cyc(S_HI,    1'b0, 1'b0);
        cyc(S_SET,   1'b0, 1'b0);
        cyc(S_RED,   1'b0, 1'b0);
    endtask

    // Monitor: every cycle with a queued expectation is compared in full.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            m_e = exp_q.pop_front();
            chk("state",    8'({curr_state2, curr_state1, curr_state0}), 8'(m_e.st));
            chk("busy",     8'(int_busy),  8'(m_e.st != S_IDLE));
            chk("ack",      8'(int_ack),   8'(m_e.ack));
            chk("error",    8'(int_error), 8'(m_e.err));
            chk("vector_q", int_vector_q,  m_e.vq);
            chk("not_used", 8'(not_used),  8'h00);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; int_req = 1'b0; int_enable = 1'b0; push_done = 1'b0;
        mem_ready = 1'b0; int_vector = 8'h00; cur_vq = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 8'({curr_state2, curr_state1, curr_state0}), 8'h00);
        chk("rst_ack",   8'(int_ack),   8'h00);
        chk("rst_error", 8'(int_error), 8'h00);
        chk("rst_vecq",  int_vector_q,  8'h00);
        chk("rst_busy",  8'(int_busy),  8'h00);
        reset = 1'b0;
        idle(2);

        // Nominal: vector 21, DRAIN for 3 cycles, 2 cycles in each IDT half.
        int_req = 1'b1; int_enable = 1'b1; int_vector = 8'h21; cur_vq = 8'h21;
        cyc(S_FLUSH, 1'b1, 1'b0);
        int_req = 1'b0; int_vector = 8'hEE;
        cyc(S_DEC, 1'b0, 1'b0);
        repeat (3) cyc(S_DRAIN, 1'b0, 1'b0);
        push_done = 1'b1; cyc(S_LO, 1'b0, 1'b0);
        push_done = 1'b0; cyc(S_LO, 1'b0, 1'b0);
        mem_ready = 1'b1; cyc(S_HI, 1'b0, 1'b0);
        mem_ready = 1'b0; cyc(S_HI, 1'b0, 1'b0);
        mem_ready = 1'b1; cyc(S_SET, 1'b0, 1'b0);
        mem_ready = 1'b0; cyc(S_RED, 1'b0, 1'b0);
        idle(2);

        // Stray push_done/mem_ready in IDLE and FLUSH change nothing.
        push_done = 1'b1; mem_ready = 1'b1;
        idle(2);
        int_req = 1'b1; int_vector = 8'h5A; cur_vq = 8'h5A;
        cyc(S_FLUSH, 1'b1, 1'b0);
        int_req = 1'b0;
        fast_tail();
        cyc(S_IDLE, 1'b0, 1'b0);
        push_done = 1'b0; mem_ready = 1'b0;
        idle(1);

        // Masking for 20 cycles, then enable; dropping enable in flight has no effect.
        int_enable = 1'b0; int_req = 1'b1; int_vector = 8'h33;
        idle(20);
        int_enable = 1'b1; cur_vq = 8'h33;
        cyc(S_FLUSH, 1'b1, 1'b0);
        int_enable = 1'b0; int_req = 1'b0; push_done = 1'b1; mem_ready = 1'b1;
        fast_tail();
        cyc(S_IDLE, 1'b0, 1'b0);
        push_done = 1'b0; mem_ready = 1'b0;
        idle(1);

        // Back-to-back: request held; second ack after one IDLE cycle, 8 cycles apart.
        int_enable = 1'b1; int_req = 1'b1; int_vector = 8'h40; cur_vq = 8'h40;
        push_done = 1'b1; mem_ready = 1'b1;
        cyc(S_FLUSH, 1'b1, 1'b0);
        int_vector = 8'h41;
        fast_tail();
        cyc(S_IDLE, 1'b0, 1'b0);
        cur_vq = 8'h41;
        cyc(S_FLUSH, 1'b1, 1'b0);
        int_req = 1'b0;
        fast_tail();
        cyc(S_IDLE, 1'b0, 1'b0);
        push_done = 1'b0; mem_ready = 1'b0;
        idle(1);

        // Reset asserted mid-cycle while in IDT_HI.
        int_req = 1'b1; int_vector = 8'h77; cur_vq = 8'h77;
        cyc(S_FLUSH, 1'b1, 1'b0);
        int_req = 1'b0;
        cyc(S_DEC, 1'b0, 1'b0);
        push_done = 1'b1; cyc(S_DRAIN, 1'b0, 1'b0);
        cyc(S_LO, 1'b0, 1'b0);
        push_done = 1'b0; mem_ready = 1'b1; cyc(S_HI, 1'b0, 1'b0);
        mem_ready = 1'b0; cyc(S_HI, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_state", 8'({curr_state2, curr_state1, curr_state0}), 8'h00);
        chk("async_rst_vecq",  int_vector_q, 8'h00);
        chk("async_rst_busy",  8'(int_busy), 8'h00);
        cur_vq = 8'h00;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        // IDT_LO with mem_ready never asserted.
        int_req = 1'b1; int_vector = 8'h99; cur_vq = 8'h99;
        cyc(S_FLUSH, 1'b1, 1'b0);
        int_req = 1'b0;
        cyc(S_DEC, 1'b0, 1'b0);
        push_done = 1'b1; cyc(S_DRAIN, 1'b0, 1'b0);
        cyc(S_LO, 1'b0, 1'b0);
        push_done = 1'b0;
`ifdef INT_TIMEOUT_EN
        repeat (255) cyc(S_LO, 1'b0, 1'b0);
        cyc(S_IDLE, 1'b0, 1'b1);
        idle(2);

        // mem_ready arriving on the saturated cycle wins over the timeout.
        int_req = 1'b1; int_vector = 8'hA5; cur_vq = 8'hA5;
        cyc(S_FLUSH, 1'b1, 1'b0);
        int_req = 1'b0;
        cyc(S_DEC, 1'b0, 1'b0);
        push_done = 1'b1; cyc(S_DRAIN, 1'b0, 1'b0);
        cyc(S_LO, 1'b0, 1'b0);
        push_done = 1'b0;
        repeat (255) cyc(S_LO, 1'b0, 1'b0);
        mem_ready = 1'b1; cyc(S_HI, 1'b0, 1'b0);
        cyc(S_SET, 1'b0, 1'b0);
        mem_ready = 1'b0; cyc(S_RED, 1'b0, 1'b0);
        idle(2);
`else
        repeat (299) cyc(S_LO, 1'b0, 1'b0);
        mem_ready = 1'b1; cyc(S_HI, 1'b0, 1'b0);
        cyc(S_SET, 1'b0, 1'b0);
        mem_ready = 1'b0; cyc(S_RED, 1'b0, 1'b0);
        idle(2);
`endif

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 8'(exp_q.size()), 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/int_sequencer_fsm.md
INT_SEQUENCER_FSM -- requirements
Module: int_sequencer_fsm

Interface
REQ-001 SHALL have: clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have: reset  input  1  asynchronous, active-high; forces IDLE immediately.
REQ-003 SHALL have: int_req  input  1  level interrupt request from the interrupt source.
REQ-004 SHALL have: int_vector  input  8  vector number, valid while int_req=1.
REQ-005 SHALL have: int_enable  input  1  architectural IF flag; 0 masks int_req.
REQ-006 SHALL have: push_done  input  1  decode reports interrupt micro-sequence pushes complete.
REQ-007 SHALL have: mem_ready  input  1  IDT read half returned this cycle.
REQ-008 SHALL have: curr_state2, curr_state1, curr_state0  output  1 each  state encoding for the interrupt output decode cloud.
REQ-009 SHALL have: not_used  output  1  constant 0, feeds the decode cloud's qualifier input.
REQ-010 SHALL have: int_ack  output  1  one-cycle pulse on request acceptance.
REQ-011 SHALL have: int_vector_q  output  8  vector latched at acceptance.
REQ-012 SHALL have: int_busy  output  1  1 in every state except IDLE.
REQ-013 SHALL have: int_error  output  1  one-cycle pulse on IDT read timeout (see Configuration).

Function
REQ-014 SHALL encode states {curr_state2,curr_state1,curr_state0}: IDLE=000, FLUSH=001, DEC_START=010, DRAIN=100, IDT_LO=011, IDT_HI=101, SETTLE=110, REDIRECT=111.
REQ-015 SHALL in IDLE move to FLUSH when int_req=1 and int_enable=1; else stay.
REQ-016 SHALL pulse int_ack and latch int_vector into int_vector_q in the same cycle as the IDLE->FLUSH transition.
REQ-017 SHALL hold FLUSH and DEC_START for exactly one cycle each: FLUSH->DEC_START->DRAIN.
REQ-018 SHALL stay in DRAIN until push_done=1, then go to IDT_LO next cycle.
REQ-019 SHALL stay in IDT_LO until mem_ready=1, then go to IDT_HI; likewise IDT_HI->SETTLE on mem_ready=1.
REQ-020 SHALL ignore mem_ready outside IDT_LO/IDT_HI and push_done outside DRAIN.
REQ-021 SHALL hold SETTLE and REDIRECT one cycle each: SETTLE->REDIRECT->IDLE.
REQ-022 SHALL not accept a new request before returning to IDLE; int_req high in REDIRECT is acked no earlier than the cycle after entering IDLE (min 8 cycles between int_ack pulses).
REQ-023 SHALL keep int_vector_q stable from acceptance until the next acceptance, regardless of int_req/int_vector changes.
REQ-024 SHALL treat int_enable dropping after acceptance as no effect on an in-flight sequence.
REQ-025 SHALL produce all outputs directly from registers (no combinational input-to-output path) except not_used.

Reset
REQ-026 SHALL on reset assertion, at any state, asynchronously set state=IDLE (000), int_ack=0, int_error=0, int_vector_q=8'h00, timeout counter=0.
REQ-027 SHALL accept a request no earlier than the first rising clk edge after reset deasserts.

Configuration
REQ-028 SHALL, with INT_TIMEOUT_EN defined, keep an 8-bit wait counter cleared on entry to IDT_LO and IDT_HI, incremented each cycle spent there with mem_ready=0.
REQ-029 SHALL, with INT_TIMEOUT_EN defined, when the counter reaches 255 with mem_ready=0, go to IDLE next cycle and pulse int_error for one cycle; mem_ready=1 in that same cycle wins (normal transition, no error).
REQ-030 SHALL, without INT_TIMEOUT_EN, omit the counter, wait indefinitely in IDT_LO/IDT_HI, and tie int_error to 0.

Verification
REQ-031 SHALL cover nominal: int_req=1, int_enable=1, int_vector=8'h21, push_done after 3 cycles, mem_ready 2 cycles after each IDT entry -> states 000,001,010,100x3,011x2,101x2,110,111,000; int_ack once; int_vector_q=8'h21.
REQ-032 SHALL cover masking: int_req=1, int_enable=0 for 20 cycles -> state stays 000, no int_ack; raise int_enable -> int_ack next edge.
REQ-033 SHALL cover reset mid-operation: assert reset during IDT_HI -> state 000 and int_vector_q=8'h00 immediately, without waiting for clk.
REQ-034 SHALL cover back-to-back: int_req held high with vector 8'h40 then 8'h41 -> second int_ack exactly one cycle after REDIRECT, int_vector_q=8'h41.
REQ-035 SHALL cover timeout (INT_TIMEOUT_EN defined): mem_ready never asserted in IDT_LO -> IDLE after 256 cycles in IDT_LO, int_error one-cycle pulse; undefined -> remains 011, int_error=0.
REQ-036 SHALL cover stray inputs: mem_ready=1 and push_done=1 while IDLE/FLUSH -> no transition beyond the normal sequence.
